// File: rtl/memory_controller_if.sv
// Core memory request bus plus console drain port; the core/testbench side is
// the master and memory_controller is the slave.
interface memory_controller_if;
  logic [31:0] memoryAddress;
  logic [31:0] memoryDataWrite;
  logic [1:0]  memoryLength;
  logic        store;
  logic        load;
  logic        loadUnsigned;
  logic [31:0] memoryDataRead;
  logic        misalignErr;
  logic [7:0]  consoleData;
  logic        consoleValid;
  logic        consoleReady;
  logic        consoleOverflow;

  modport master (
    output memoryAddress, memoryDataWrite, memoryLength, store, load,
           loadUnsigned, consoleReady,
    input  memoryDataRead, misalignErr, consoleData, consoleValid, consoleOverflow
  );

  modport slave (
    input  memoryAddress, memoryDataWrite, memoryLength, store, load,
           loadUnsigned, consoleReady,
    output memoryDataRead, misalignErr, consoleData, consoleValid, consoleOverflow
  );
endinterface

// File: rtl/memory_controller.sv
// Single-port byte-addressed memory with registered loads, byte-enabled stores and
// an optional memory-mapped console TX FIFO enabled by defining CONSOLE_FIFO_EN.
module memory_controller #(
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] CONSOLE_ADDR    = 32'hFFFF_FFF0,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  memory_controller_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  logic [31:0]   r_mem [MEM_DEPTH_WORDS];
  logic [31:0]   r_rdata;
  logic          r_misalign;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_misalign;
  logic          w_cons_data;
  logic          w_cons_stat;
  logic          w_array_store;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ext;
  logic [31:0]   w_load_val;
  logic [31:0]   w_status;

  assign w_idx   = bus.memoryAddress[AW+1:2];
  assign w_off   = bus.memoryAddress[1:0];
  assign w_rword = r_mem[w_idx];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'hF;
    w_wdata    = bus.memoryDataWrite;
    case (bus.memoryLength)
      2'd0: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{bus.memoryDataWrite[7:0]}};
      end
      2'd1: begin
        w_misalign = w_off[0];
        w_be       = 4'b0011 << w_off;
        w_wdata    = {2{bus.memoryDataWrite[15:0]}};
      end
      default: w_misalign = |w_off;
    endcase
  end

  always_comb begin
    w_shifted = w_rword >> {w_off, 3'b000};
    case (bus.memoryLength)
      2'd0:    w_ext = bus.loadUnsigned ? {24'b0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ext = bus.loadUnsigned ? {16'b0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_rword;
    endcase
  end

  // Console registers are fully decoded and shadow the aliased array words.
  always_comb begin
    w_load_val = w_ext;
    if (w_cons_data)      w_load_val = '0;
    else if (w_cons_stat) w_load_val = w_status;
    else if (w_misalign)  w_load_val = '0;
  end

  assign w_array_store = bus.store && !w_misalign && !w_cons_data && !w_cons_stat;

  // NOTE: the array has no reset branch; clearing it would need a write port per word.
  always_ff @(posedge clk) begin
    if (!reset && w_array_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (bus.load) r_rdata <= w_load_val;
      if ((bus.load || bus.store) && w_misalign) r_misalign <= 1'b1;
    end
  end

  assign bus.memoryDataRead = r_rdata;
  assign bus.misalignErr    = r_misalign;

`ifdef CONSOLE_FIFO_EN
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [FW:0]   r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_do_push;

  assign w_cons_data = (bus.memoryAddress == CONSOLE_ADDR);
  assign w_cons_stat = (bus.memoryAddress == CONSOLE_ADDR + 32'd4);
  assign w_full      = (r_count == (FW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.store && w_cons_data;
  assign w_pop       = !w_empty && bus.consoleReady;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_push   = w_push && (!w_full || w_pop);
  assign w_status    = {29'b0, r_overflow, w_full, w_empty};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (FW+1)'(w_do_push) - (FW+1)'(w_pop);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_fifo[r_wr_ptr] <= bus.memoryDataWrite[7:0];
  end

  assign bus.consoleValid    = !w_empty;
  assign bus.consoleData     = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign bus.consoleOverflow = r_overflow;
`else
  logic w_unused;

  assign w_cons_data         = 1'b0;
  assign w_cons_stat         = 1'b0;
  assign w_status            = '0;
  assign bus.consoleValid    = 1'b0;
  assign bus.consoleData     = 8'h00;
  assign bus.consoleOverflow = 1'b0;
  assign w_unused            = ^{bus.memoryAddress[31:AW+2], bus.consoleReady};
`endif
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: a byte-array/queue reference model
// predicts load data, a monitor compares each registered load result.
module tb_memory_controller;
  localparam int          DEPTH = 1024;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] CADDR = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_controller_if bus ();

  memory_controller #(
    .MEM_DEPTH_WORDS(DEPTH),
    .CONSOLE_ADDR   (CADDR),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  ref_mem [BYTES];
  logic [31:0] exp_q [$];
  logic [7:0]  fifo_q [$];
  logic        exp_mis = 1'b0;
  logic        exp_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] len);
    return (len == 2'd1 && a[0]) || (len[1] && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] len, input bit uns);
    logic [31:0] v = '0;
`ifdef CONSOLE_FIFO_EN
    if (a == CADDR) return 32'h0;
    if (a == CADDR + 32'd4)
      return {29'b0, exp_ovf, fifo_q.size() == 4, fifo_q.size() == 0};
`endif
    if (is_mis(a, len)) return 32'h0;
    for (int i = 0; i < nbytes(len); i++)
      v |= 32'(ref_mem[int'((a + 32'(i)) % BYTES)]) << (8 * i);
    if (!uns && len == 2'd0 && v[7])  v |= 32'hFFFF_FF00;
    if (!uns && len == 2'd1 && v[15]) v |= 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    if (is_mis(a, len)) return;
    for (int i = 0; i < nbytes(len); i++)
      ref_mem[int'((a + 32'(i)) % BYTES)] = d[8*i +: 8];
  endfunction

  // One bus cycle: drive at negedge, predict, return 2 time units after the edge.
  task automatic req(input bit st, input bit ld, input logic [1:0] len, input bit uns,
                     input logic [31:0] a, input logic [31:0] d, input bit rdy = 1'b0);
    bit pop_ok;
    @(negedge clk);
    bus.store           = st;
    bus.load            = ld;
    bus.memoryLength    = len;
    bus.loadUnsigned    = uns;
    bus.memoryAddress   = a;
    bus.memoryDataWrite = d;
    bus.consoleReady    = rdy;
    if (reset) begin
      fifo_q.delete();
      exp_ovf = 1'b0;
      exp_mis = 1'b0;
    end else begin
      if (ld) exp_q.push_back(model_load(a, len, uns));
      if ((st || ld) && is_mis(a, len)) exp_mis = 1'b1;
`ifdef CONSOLE_FIFO_EN
      pop_ok = rdy && fifo_q.size() > 0;
      if (pop_ok) void'(fifo_q.pop_front());
      if (st && a == CADDR) begin
        if (fifo_q.size() < 4) fifo_q.push_back(d[7:0]);
        else exp_ovf = 1'b1;
      end else if (st && a != CADDR + 32'd4) model_store(a, len, d);
`else
      pop_ok = 1'b0;
      if (st) model_store(a, len, d);
`endif
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rdy = 1'b0);
    req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  // Monitor: every load accepted at an edge must match the next predicted value.
  initial begin
    forever begin
      bit sampled;
      @(posedge clk);
      sampled = bus.load && !reset;
      #1;
      if (sampled) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_unexpected: got %h expected none", bus.memoryDataRead);
        end else begin
          check("rdata", bus.memoryDataRead, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check("rst_rdata", bus.memoryDataRead, 32'h0);
    check("rst_mis", 32'(bus.misalignErr), 32'h0);
    check("rst_cvalid", 32'(bus.consoleValid), 32'h0);
    check("rst_cdata", 32'(bus.consoleData), 32'h0);
    check("rst_covf", 32'(bus.consoleOverflow), 32'h0);

    for (int w = 0; w < DEPTH; w++) req(1, 0, 2'd2, 0, 32'(w * 4), 32'h0);

    req(1, 0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
    req(0, 1, 2'd2, 0, 32'h10, 32'h0);
    check("word_rb", bus.memoryDataRead, 32'hDEAD_BEEF);
    req(1, 0, 2'd0, 0, 32'h21, 32'h80);
    req(0, 1, 2'd0, 0, 32'h21, 32'h0);
    check("byte_sext", bus.memoryDataRead, 32'hFFFF_FF80);
    req(0, 1, 2'd0, 1, 32'h21, 32'h0);
    check("byte_zext", bus.memoryDataRead, 32'h0000_0080);
    req(0, 1, 2'd2, 0, 32'h20, 32'h0);
    check("byte_lane", bus.memoryDataRead, 32'h0000_8000);
    req(1, 1, 2'd2, 0, 32'h30, 32'h1234_5678);
    check("rbw_old", bus.memoryDataRead, 32'h0);
    req(0, 1, 2'd2, 0, 32'h30, 32'h0);
    check("rbw_new", bus.memoryDataRead, 32'h1234_5678);
    req(1, 0, 2'd2, 0, 32'(DEPTH * 4 + 8), 32'hA5A5_A5A5);
    req(0, 1, 2'd2, 0, 32'h8, 32'h0);
    check("alias", bus.memoryDataRead, 32'hA5A5_A5A5);
    req(1, 0, 2'd2, 0, CADDR, 32'hCAFE_F00D);
    req(0, 1, 2'd2, 0, CADDR, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [1:0]  len;
      len = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 7) != 0) a &= ~((len == 2'd0) ? 32'h0 : (len == 2'd1) ? 32'h1 : 32'h3);
`ifndef CONSOLE_FIFO_EN
      if ($urandom_range(0, 15) == 0) a = CADDR + 32'($urandom_range(0, 1) * 4);
`endif
      req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len,
          1'($urandom_range(0, 1)), a, $urandom);
    end
    check("rand_mis", 32'(bus.misalignErr), 32'(exp_mis));
    check("cvalid_idle", 32'(bus.consoleValid), 32'(fifo_q.size() != 0));

    reset = 1'b1;
    idle();
    reset = 1'b0;
    req(1, 0, 2'd2, 0, 32'h10, 32'h1122_3344);
    check("mis_clear", 32'(bus.misalignErr), 32'h0);
    req(1, 0, 2'd1, 0, 32'h13, 32'h0000_FFFF);
    check("mis_set", 32'(bus.misalignErr), 32'h1);
    req(0, 1, 2'd2, 0, 32'h10, 32'h0);
    check("mis_nowrite", bus.memoryDataRead, 32'h1122_3344);
    req(0, 1, 2'd2, 0, 32'h12, 32'h0);
    check("mis_load0", bus.memoryDataRead, 32'h0);
    idle();
    check("mis_sticky", 32'(bus.misalignErr), 32'h1);

`ifdef CONSOLE_FIFO_EN
    req(1, 0, 2'd0, 0, CADDR, 32'h48);
    req(1, 0, 2'd2, 0, CADDR, 32'h69);
    req(1, 0, 2'd1, 0, CADDR, 32'h21);
    req(1, 0, 2'd0, 0, CADDR, 32'h0A);
    req(1, 0, 2'd0, 0, CADDR, 32'h58);
    req(0, 1, 2'd2, 0, CADDR + 32'd4, 32'h0);
    check("status_full_ovf", bus.memoryDataRead, 32'h6);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(bus.consoleValid), 32'h1);
      check("drain_data", 32'(bus.consoleData), 32'(fifo_q[0]));
      idle(1'b1);
    end
    check("drain_empty", 32'(bus.consoleValid), 32'h0);

    reset = 1'b1;
    idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) req(1, 0, 2'd0, 0, CADDR, 32'(8'h30 + i));
    req(1, 0, 2'd0, 0, CADDR, 32'h5A, 1'b1);
    check("pushpop_noovf", 32'(bus.consoleOverflow), 32'h0);
    req(0, 1, 2'd2, 0, CADDR + 32'd4, 32'h0);
    check("pushpop_full", bus.memoryDataRead, 32'h2);
    check("pushpop_head", 32'(bus.consoleData), 32'(fifo_q[0]));
`endif

    req(0, 1, 2'd2, 0, 32'h8, 32'h0, 1'b1);
    reset = 1'b1;
    req(0, 1, 2'd2, 0, 32'h8, 32'h0, 1'b1);
    check("midrst_rdata", bus.memoryDataRead, 32'h0);
    check("midrst_cvalid", 32'(bus.consoleValid), 32'h0);
    reset = 1'b0;
    idle();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
